// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the ILI9341-class SPI LCD decoder.
// Holds the command/COLMOD codes, the FSM and bpp enums, and the colour expanders.
package lcd_spi_pkg;

   localparam logic [7:0] CMD_CASET  = 8'h2A;
   localparam logic [7:0] CMD_PASET  = 8'h2B;
   localparam logic [7:0] CMD_RAMWR  = 8'h2C;
   localparam logic [7:0] CMD_RAMWRC = 8'h3C;
   localparam logic [7:0] CMD_COLMOD = 8'h3A;

   localparam logic [7:0] COLMOD_16  = 8'h55;
   localparam logic [7:0] COLMOD_18  = 8'h66;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CASET,
      ST_PASET,
      ST_COLMOD,
      ST_RAMWR
   } state_t;

   typedef enum logic {
      BPP_16,
      BPP_18
   } bpp_t;

   // Replicate the top bits into the low bits so full-scale maps to 0xFF.
   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic logic [7:0] expand6(input logic [5:0] c);
      return {c, c[5:4]};
   endfunction

endpackage

// File: rtl/lcd_spi_decoder_if.sv
// Panel-side SPI lines in, decoded pixel events out.
// master = traffic source / pixel consumer, slave = the decoder.
interface lcd_spi_decoder_if #(
   parameter int XW = 8,
   parameter int YW = 9
);
   logic          csn_i;
   logic          clk_i;
   logic          sdi_i;
   logic          dcn_i;
   logic [XW-1:0] x_o;
   logic [YW-1:0] y_o;
   logic [7:0]    r_o;
   logic [7:0]    g_o;
   logic [7:0]    b_o;
   logic          strobe_o;

   modport master (
      output csn_i, clk_i, sdi_i, dcn_i,
      input  x_o, y_o, r_o, g_o, b_o, strobe_o
   );

   modport slave (
      input  csn_i, clk_i, sdi_i, dcn_i,
      output x_o, y_o, r_o, g_o, b_o, strobe_o
   );
endinterface

// File: rtl/lcd_spi_rx.sv
// Oversampling SPI receiver: 2-FF synchronisers, SCLK rising-edge detect and
// frame shifter producing one byte + D/C flag per completed 8- or 9-bit frame.
module lcd_spi_rx #(
   parameter bit THREE_WIRE = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       csn,
   input  logic       sclk,
   input  logic       sdi,
   input  logic       dcn,
   output logic [7:0] data,
   output logic       dc,
   output logic       valid,
   output logic       csn_rise
);
   localparam logic [3:0] LAST_BIT = THREE_WIRE ? 4'd8 : 4'd7;

   logic [3:0] meta_reg;
   logic [3:0] sync_reg;
   logic       sclk_prev_reg;
   logic       csn_prev_reg;
   logic       armed_reg;
   logic [3:0] bit_cnt_reg;
   logic [6:0] shift_reg;
   logic       first_bit_reg;

   logic csn_s, sclk_s, sdi_s, dcn_s;
   assign {csn_s, sclk_s, sdi_s, dcn_s} = sync_reg;

   // csn sync resets to "selected" and armed_reg only sets once csn is seen high,
   // so a frame already in flight at reset release is ignored until a fresh select.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta_reg      <= '0;
         sync_reg      <= '0;
         sclk_prev_reg <= 1'b0;
         csn_prev_reg  <= 1'b0;
         armed_reg     <= 1'b0;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         first_bit_reg <= 1'b0;
         data          <= '0;
         dc            <= 1'b0;
         valid         <= 1'b0;
         csn_rise      <= 1'b0;
      end else begin
         meta_reg      <= {csn, sclk, sdi, dcn};
         sync_reg      <= meta_reg;
         sclk_prev_reg <= sclk_s;
         csn_prev_reg  <= csn_s;
         armed_reg     <= armed_reg | csn_s;
         csn_rise      <= csn_s & ~csn_prev_reg;
         valid         <= 1'b0;
         if (csn_s) begin
            bit_cnt_reg <= '0;
         end else if (armed_reg && sclk_s && !sclk_prev_reg) begin
            shift_reg <= {shift_reg[5:0], sdi_s};
            if (bit_cnt_reg == 4'd0)
               first_bit_reg <= sdi_s;
            if (bit_cnt_reg == LAST_BIT) begin
               bit_cnt_reg <= '0;
               valid       <= 1'b1;
               data        <= {shift_reg, sdi_s};
               dc          <= THREE_WIRE ? first_bit_reg : dcn_s;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
         end
      end
   end
endmodule

// File: rtl/lcd_spi_decoder.sv
// ILI9341-class command decoder: window/COLMOD registers, pixel assembly and
// the auto-advancing x/y pointer, emitting one strobed RGB888 event per pixel.
module lcd_spi_decoder
   import lcd_spi_pkg::*;
#(
   parameter int WIDTH      = 240,
   parameter int HEIGHT     = 320,
   parameter bit THREE_WIRE = 1'b0,
   parameter int XW         = $clog2(WIDTH),
   parameter int YW         = $clog2(HEIGHT)
) (
   input logic               clock,
   input logic               reset,
   lcd_spi_decoder_if.slave  bus
);
   localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

   logic [7:0] rx_data;
   logic       rx_dc, rx_valid, rx_csn_rise;

   lcd_spi_rx #(.THREE_WIRE(THREE_WIRE)) u_rx (
      .clock    (clock),
      .reset    (reset),
      .csn      (bus.csn_i),
      .sclk     (bus.clk_i),
      .sdi      (bus.sdi_i),
      .dcn      (bus.dcn_i),
      .data     (rx_data),
      .dc       (rx_dc),
      .valid    (rx_valid),
      .csn_rise (rx_csn_rise)
   );

   state_t          state_reg;
   bpp_t            bpp_reg;
   logic [2:0]      param_cnt_reg;
   logic [2:0][7:0] param_reg;
   logic [XW-1:0]   sc_reg, ec_reg, x_ptr_reg, x_reg;
   logic [YW-1:0]   sp_reg, ep_reg, y_ptr_reg, y_reg;
   logic [1:0]      pix_cnt_reg;
   logic [1:0][7:0] pix_reg;
   logic [7:0]      r_reg, g_reg, b_reg;
   logic            strobe_reg;

   logic        pix_done, x_wrap, y_wrap;
   logic [23:0] pix_rgb;

   function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
      return (v > 16'(WIDTH - 1)) ? X_MAX : XW'(v);
   endfunction

   function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
      return (v > 16'(HEIGHT - 1)) ? Y_MAX : YW'(v);
   endfunction

   always_comb begin
      pix_done = (bpp_reg == BPP_16) ? (pix_cnt_reg == 2'd1) : (pix_cnt_reg == 2'd2);
      if (bpp_reg == BPP_16)
         pix_rgb = {expand5(pix_reg[0][7:3]), expand6({pix_reg[0][2:0], rx_data[7:5]}),
                    expand5(rx_data[4:0])};
      else
         pix_rgb = {expand6(pix_reg[0][7:2]), expand6(pix_reg[1][7:2]), expand6(rx_data[7:2])};
      // An inverted window pins that axis at its start and pushes every step onward.
      x_wrap = (sc_reg > ec_reg) || (x_ptr_reg == ec_reg);
      y_wrap = (sp_reg > ep_reg) || (y_ptr_reg == ep_reg);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         bpp_reg       <= BPP_16;
         param_cnt_reg <= '0;
         param_reg     <= '0;
         sc_reg        <= '0;
         ec_reg        <= X_MAX;
         sp_reg        <= '0;
         ep_reg        <= Y_MAX;
         x_ptr_reg     <= '0;
         y_ptr_reg     <= '0;
         pix_cnt_reg   <= '0;
         pix_reg       <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
         r_reg         <= '0;
         g_reg         <= '0;
         b_reg         <= '0;
         strobe_reg    <= 1'b0;
      end else begin
         strobe_reg <= 1'b0;
         if (rx_valid && !rx_dc) begin
            param_cnt_reg <= '0;
            pix_cnt_reg   <= '0;
            case (rx_data)
               CMD_CASET:  state_reg <= ST_CASET;
               CMD_PASET:  state_reg <= ST_PASET;
               CMD_COLMOD: state_reg <= ST_COLMOD;
               CMD_RAMWR: begin
                  state_reg <= ST_RAMWR;
                  x_ptr_reg <= sc_reg;
                  y_ptr_reg <= sp_reg;
               end
               CMD_RAMWRC: state_reg <= ST_RAMWR;
               default:    state_reg <= ST_IDLE;
            endcase
         end else if (rx_valid) begin
            case (state_reg)
               ST_CASET, ST_PASET: begin
                  if (param_cnt_reg < 3'd3) begin
                     param_reg[param_cnt_reg[1:0]] <= rx_data;
                     param_cnt_reg <= param_cnt_reg + 3'd1;
                  end else if (param_cnt_reg == 3'd3) begin
                     param_cnt_reg <= 3'd4;
                     if (state_reg == ST_CASET) begin
                        sc_reg <= clamp_x({param_reg[0], param_reg[1]});
                        ec_reg <= clamp_x({param_reg[2], rx_data});
                     end else begin
                        sp_reg <= clamp_y({param_reg[0], param_reg[1]});
                        ep_reg <= clamp_y({param_reg[2], rx_data});
                     end
                  end
               end
               ST_COLMOD: begin
                  if (rx_data == COLMOD_16)
                     bpp_reg <= BPP_16;
                  else if (rx_data == COLMOD_18)
                     bpp_reg <= BPP_18;
               end
               ST_RAMWR: begin
                  if (pix_done) begin
                     strobe_reg            <= 1'b1;
                     x_reg                 <= x_ptr_reg;
                     y_reg                 <= y_ptr_reg;
                     {r_reg, g_reg, b_reg} <= pix_rgb;
                     pix_cnt_reg           <= '0;
                     if (x_wrap) begin
                        x_ptr_reg <= sc_reg;
                        y_ptr_reg <= y_wrap ? sp_reg : y_ptr_reg + 1'b1;
                     end else begin
                        x_ptr_reg <= x_ptr_reg + 1'b1;
                     end
                  end else begin
                     pix_reg[pix_cnt_reg[0]] <= rx_data;
                     pix_cnt_reg             <= pix_cnt_reg + 2'd1;
                  end
               end
               default: ;
            endcase
         end
         // Deselect wins over a frame finishing in the same cycle (frame already used above).
         if (rx_csn_rise) begin
            state_reg     <= ST_IDLE;
            param_cnt_reg <= '0;
            pix_cnt_reg   <= '0;
         end
      end
   end

   assign bus.x_o      = x_reg;
   assign bus.y_o      = y_reg;
   assign bus.r_o      = r_reg;
   assign bus.g_o      = g_reg;
   assign bus.b_o      = b_reg;
   assign bus.strobe_o = strobe_reg;
endmodule

// File: tb/tb_lcd_spi_decoder.sv
// Scoreboard bench: expected pixels are queued as SPI traffic is driven and
// popped as each DUT strobes; covers 4-wire and 3-wire decoders.
module tb_lcd_spi_decoder;
   import lcd_spi_pkg::*;

   localparam int XW = 8;
   localparam int YW = 9;
   typedef logic [XW+YW+23:0] pix_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic csn4 = 1'b0, csn3 = 1'b1, sclk = 1'b0, sdi = 1'b0, dcn = 1'b1;

   always #5 clock = ~clock;

   lcd_spi_decoder_if #(.XW(XW), .YW(YW)) bus4 ();
   lcd_spi_decoder_if #(.XW(XW), .YW(YW)) bus3 ();

   assign bus4.csn_i = csn4;
   assign bus4.clk_i = sclk;
   assign bus4.sdi_i = sdi;
   assign bus4.dcn_i = dcn;
   assign bus3.csn_i = csn3;
   assign bus3.clk_i = sclk;
   assign bus3.sdi_i = sdi;
   assign bus3.dcn_i = dcn;

   lcd_spi_decoder #(.WIDTH(240), .HEIGHT(320), .THREE_WIRE(1'b0)) dut4 (
      .clock(clock), .reset(reset), .bus(bus4));
   lcd_spi_decoder #(.WIDTH(240), .HEIGHT(320), .THREE_WIRE(1'b1)) dut3 (
      .clock(clock), .reset(reset), .bus(bus3));

   int   errors = 0;
   int   checks = 0;
   pix_t exp4[$];
   pix_t exp3[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, want);
      end
   endtask

   function automatic pix_t px(input int x, input int y, input logic [23:0] rgb);
      return {XW'(x), YW'(y), rgb};
   endfunction

   function automatic logic [23:0] c565(input logic [15:0] c);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r5 = c[15:11];
      g6 = c[10:5];
      b5 = c[4:0];
      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
   endfunction

   always @(negedge clock) begin
      if (bus4.strobe_o === 1'b1) begin
         $display("pix4 x=%0d y=%0d rgb=%h%h%h", bus4.x_o, bus4.y_o, bus4.r_o, bus4.g_o, bus4.b_o);
         if (exp4.size() == 0)
            check("strobe4_extra", 64'(bus4.strobe_o), 64'd0);
         else
            check("pix4", 64'({bus4.x_o, bus4.y_o, bus4.r_o, bus4.g_o, bus4.b_o}), 64'(exp4.pop_front()));
      end
      if (bus3.strobe_o === 1'b1) begin
         $display("pix3 x=%0d y=%0d rgb=%h%h%h", bus3.x_o, bus3.y_o, bus3.r_o, bus3.g_o, bus3.b_o);
         if (exp3.size() == 0)
            check("strobe3_extra", 64'(bus3.strobe_o), 64'd0);
         else
            check("pix3", 64'({bus3.x_o, bus3.y_o, bus3.r_o, bus3.g_o, bus3.b_o}), 64'(exp3.pop_front()));
      end
   end

   // Pins change on 10 ns multiples, clock edges sit at 5 ns offsets; SCLK = clock/4.
   task automatic spi_bits(input logic [8:0] bits, input int n, input logic dc_pin);
      dcn = dc_pin;
      for (int i = n - 1; i >= 0; i--) begin
         sdi  = bits[i];
         sclk = 1'b0;
         #20;
         sclk = 1'b1;
         #20;
      end
      sclk = 1'b0;
   endtask

   task automatic tx4(input logic dc, input logic [7:0] b);
      spi_bits({1'b0, b}, 8, dc);
   endtask

   task automatic tx3(input logic dc, input logic [7:0] b);
      spi_bits({dc, b}, 9, 1'b1);
   endtask

   task automatic cs4_low();
      csn4 = 1'b0;
      #40;
   endtask

   task automatic cs4_high();
      #20;
      csn4 = 1'b1;
      #80;
   endtask

   initial begin
      int xs[7];
      int ys[7];
      logic [15:0] c;
      xs = '{10, 11, 12, 10, 11, 12, 10};
      ys = '{5, 5, 5, 6, 6, 6, 5};

      #100;
      check("rst_x", 64'(bus4.x_o), 64'd0);
      check("rst_y", 64'(bus4.y_o), 64'd0);
      check("rst_rgb", 64'({bus4.r_o, bus4.g_o, bus4.b_o}), 64'd0);
      check("rst_strobe4", 64'(bus4.strobe_o), 64'd0);
      check("rst_strobe3", 64'(bus3.strobe_o), 64'd0);
      reset = 1'b1;
      #40;

      // csn held low across reset release: no fresh select, so this must be ignored
      tx4(1'b0, CMD_RAMWR); tx4(1'b1, 8'hF8); tx4(1'b1, 8'h00);
      cs4_high();
      check("unarmed_rgb", 64'({bus4.r_o, bus4.g_o, bus4.b_o}), 64'd0);

      cs4_low();
      tx4(1'b0, CMD_RAMWR);
      exp4.push_back(px(0, 0, 24'hFF0000));
      tx4(1'b1, 8'hF8); tx4(1'b1, 8'h00);
      cs4_high();

      // partial pixel dropped at deselect
      cs4_low();
      tx4(1'b0, CMD_RAMWR); tx4(1'b1, 8'hF8);
      cs4_high();
      cs4_low();
      tx4(1'b0, CMD_RAMWR);
      exp4.push_back(px(0, 0, 24'h0000FF));
      tx4(1'b1, 8'h00); tx4(1'b1, 8'h1F);
      cs4_high();

      cs4_low();
      tx4(1'b0, CMD_CASET); tx4(1'b1, 8'h00); tx4(1'b1, 8'd10); tx4(1'b1, 8'h00); tx4(1'b1, 8'd12);
      tx4(1'b0, CMD_PASET); tx4(1'b1, 8'h00); tx4(1'b1, 8'd5);  tx4(1'b1, 8'h00); tx4(1'b1, 8'd6);
      tx4(1'b0, CMD_RAMWR);
      for (int i = 0; i < 7; i++) begin
         c = 16'((i + 1) * 9029);
         exp4.push_back(px(xs[i], ys[i], c565(c)));
         tx4(1'b1, c[15:8]); tx4(1'b1, c[7:0]);
      end
      // partial pixel dropped by a following command
      tx4(1'b1, 8'hAB);
      tx4(1'b0, CMD_COLMOD); tx4(1'b1, COLMOD_18);
      tx4(1'b0, CMD_RAMWR);
      exp4.push_back(px(10, 5, 24'hFF0082));
      tx4(1'b1, 8'hFC); tx4(1'b1, 8'h00); tx4(1'b1, 8'h80);
      tx4(1'b0, CMD_COLMOD); tx4(1'b1, 8'h12);
      tx4(1'b0, CMD_RAMWRC);
      exp4.push_back(px(11, 5, 24'h0000FF));
      tx4(1'b1, 8'h00); tx4(1'b1, 8'h00); tx4(1'b1, 8'hFC);
      cs4_high();

      // clamped, degenerate column window; fifth parameter byte ignored
      cs4_low();
      tx4(1'b0, CMD_COLMOD); tx4(1'b1, COLMOD_16);
      tx4(1'b0, CMD_CASET); tx4(1'b1, 8'h01); tx4(1'b1, 8'h00); tx4(1'b1, 8'h01); tx4(1'b1, 8'h20);
      tx4(1'b1, 8'h00);
      tx4(1'b0, CMD_RAMWR);
      for (int i = 0; i < 3; i++) begin
         c = 16'(16'hF81F - i * 16'h0841);
         exp4.push_back(px(239, (i == 1) ? 6 : 5, c565(c)));
         tx4(1'b1, c[15:8]); tx4(1'b1, c[7:0]);
      end
      cs4_high();
      // pointer survives deselect; RAMWRC continues from it
      cs4_low();
      tx4(1'b0, CMD_RAMWRC);
      exp4.push_back(px(239, 6, 24'h00FF00));
      tx4(1'b1, 8'h07); tx4(1'b1, 8'hE0);
      cs4_high();

      csn3 = 1'b0;
      #40;
      tx3(1'b0, CMD_RAMWR);
      exp3.push_back(px(0, 0, 24'h00FF00));
      tx3(1'b1, 8'h07); tx3(1'b1, 8'hE0);
      exp3.push_back(px(1, 0, 24'hFF0000));
      tx3(1'b1, 8'hF8); tx3(1'b1, 8'h00);
      #20;
      csn3 = 1'b1;

      #400;
      check("left4", 64'(exp4.size()), 64'd0);
      check("left3", 64'(exp3.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
